// File: rtl/adder_seq_ctrl.sv
// Multi-beat ADD/SUB sequencer: runs a WIDTH-bit operation through an external
// SLICE-bit adder one slice per clock, least-significant slice first, and reports NZCV.
module adder_seq_ctrl #(
  parameter int WIDTH = 64,
  parameter int SLICE = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             flag_n,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v,
  output logic [SLICE-1:0] add_a,
  output logic [SLICE-1:0] add_b,
  output logic             add_cin,
  input  logic [SLICE-1:0] add_sum,
  input  logic             add_cout
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [IDX_W-1:0] idx;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             carry_reg;
  logic             last_beat;

  assign last_beat = (idx == LAST_IDX);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // The adder ports are only driven during RUN so the shared adder sees zeros otherwise.
  always_comb begin
    state_next = state;
    ready      = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    add_a      = '0;
    add_b      = '0;
    add_cin    = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) state_next = RUN;
      end
      RUN: begin
        busy    = 1'b1;
        add_a   = a_reg[idx*SLICE +: SLICE];
        add_b   = b_reg[idx*SLICE +: SLICE];
        add_cin = carry_reg;
        if (last_beat) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // SUB is a + ~b + 1, so the inversion and the +1 carry are folded in at accept time.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx       <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      carry_reg <= 1'b0;
      result    <= '0;
      flag_n    <= 1'b0;
      flag_z    <= 1'b0;
      flag_c    <= 1'b0;
      flag_v    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_reg     <= op_a;
            b_reg     <= sub ? ~op_b : op_b;
            carry_reg <= sub;
            idx       <= '0;
          end
        end
        RUN: begin
          result[idx*SLICE +: SLICE] <= add_sum;
          carry_reg                  <= add_cout;
          idx                        <= idx + 1'b1;
          if (last_beat) begin
            flag_n <= add_sum[SLICE-1];
            flag_z <= (result[WIDTH-SLICE-1:0] == '0) && (add_sum == '0);
            flag_c <= add_cout;
            flag_v <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                      (add_sum[SLICE-1] != a_reg[WIDTH-1]);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Directed bench for adder_seq_ctrl with a behavioural 16-bit adder on the add_* ports.
module tb_adder_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        sub = 1'b0;
  logic [63:0] op_a = '0;
  logic [63:0] op_b = '0;
  logic        ready, busy, done;
  logic [63:0] result;
  logic        flag_n, flag_z, flag_c, flag_v;
  logic [15:0] add_a, add_b, add_sum;
  logic        add_cin, add_cout;

  int total = 0;
  int bad = 0;
  int done_count = 0;
  int done_cyc;
  logic [3:0] beat_cin;
  logic [3:0] beat_cout;
  time t_first;
  time t_second;

  adder_seq_ctrl #(.WIDTH(64), .SLICE(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub),
    .op_a(op_a), .op_b(op_b), .ready(ready), .busy(busy), .done(done),
    .result(result), .flag_n(flag_n), .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout)
  );

  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {16'd0, add_cin};

  always #5 clk = ~clk;

  always @(posedge clk) if (done) done_count++;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Launch one operation and wait for done; optionally poke start while busy/done.
  task automatic apply_stimulus(input logic s, input logic [63:0] a, input logic [63:0] b,
                                input bit inject);
    sub   = s;
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    op_a  = ~a;
    op_b  = ~b;
    sub   = ~s;
    done_cyc  = 0;
    beat_cin  = '0;
    beat_cout = '0;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      if (busy && cyc <= 4) begin
        beat_cin[cyc-1]  = add_cin;
        beat_cout[cyc-1] = add_cout;
      end
      if (inject && cyc == 2) begin
        start = 1'b1;
        op_a  = 64'h1234;
        op_b  = 64'h5678;
      end
      if (inject && cyc == 3) start = 1'b0;
      if (inject && cyc == 5) start = 1'b1;
      if (done) begin
        done_cyc = cyc;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic do_op(input string tag, input logic s, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] exp_res,
                       input logic [3:0] exp_nzcv, input bit inject);
    int dc0;
    dc0 = done_count;
    apply_stimulus(s, a, b, inject);
    check_output({tag, " latency"}, 64'(done_cyc), 64'd5);
    check_output({tag, " result"}, result, exp_res);
    check_output({tag, " nzcv"}, {60'd0, flag_n, flag_z, flag_c, flag_v}, {60'd0, exp_nzcv});
    check_output({tag, " ready_in_done"}, {63'd0, ready}, 64'd0);
    @(posedge clk); #1;
    start = 1'b0;
    check_output({tag, " ready_after"}, {63'd0, ready}, 64'd1);
    check_output({tag, " busy_after"}, {63'd0, busy}, 64'd0);
    check_output({tag, " done_after"}, {63'd0, done}, 64'd0);
    check_output({tag, " held_result"}, result, exp_res);
    check_output({tag, " done_count"}, 64'(done_count - dc0), 64'd1);
  endtask

  initial begin
    int dc0;
    $display("[TB] start");

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_output("rst ready", {63'd0, ready}, 64'd1);
    check_output("rst busy", {63'd0, busy}, 64'd0);
    check_output("rst done", {63'd0, done}, 64'd0);
    check_output("rst result", result, 64'd0);
    check_output("rst nzcv", {60'd0, flag_n, flag_z, flag_c, flag_v}, 64'd0);
    check_output("rst add_ab", {32'd0, add_a, add_b}, 64'd0);
    check_output("rst add_cin", {63'd0, add_cin}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_op("add_carry16", 1'b0, 64'h0000_0000_0000_FFFF, 64'h1,
          64'h0000_0000_0001_0000, 4'b0000, 1'b0);
    check_output("add_carry16 beat0 cout", {63'd0, beat_cout[0]}, 64'd1);
    check_output("add_carry16 beat1 cin", {63'd0, beat_cin[1]}, 64'd1);

    do_op("add_wrap", 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h0, 4'b0110, 1'b0);
    do_op("add_ovf", 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1,
          64'h8000_0000_0000_0000, 4'b1001, 1'b0);

    do_op("sub_neg", 1'b1, 64'd5, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 4'b1000, 1'b0);
    check_output("sub_neg beat0 cin", {63'd0, beat_cin[0]}, 64'd1);
    do_op("sub_pos", 1'b1, 64'd7, 64'd5, 64'd2, 4'b0010, 1'b0);

    t_first = $time;
    do_op("ignore_start", 1'b0, 64'd10, 64'd20, 64'd30, 4'b0000, 1'b1);
    t_second = $time;
    do_op("back2back", 1'b1, 64'h100, 64'h1, 64'hFF, 4'b0010, 1'b0);
    check_output("accept spacing", 64'((t_second - t_first) / 10), 64'd6);

    sub   = 1'b0;
    op_a  = 64'd100;
    op_b  = 64'd200;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_output("abort busy_beat2", {63'd0, busy}, 64'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_output("abort ready", {63'd0, ready}, 64'd1);
    check_output("abort busy", {63'd0, busy}, 64'd0);
    check_output("abort result", result, 64'd0);
    check_output("abort nzcv", {60'd0, flag_n, flag_z, flag_c, flag_v}, 64'd0);
    dc0 = done_count;
    repeat (6) begin
      @(posedge clk); #1;
    end
    check_output("abort no_done", 64'(done_count - dc0), 64'd0);
    do_op("after_abort", 1'b0, 64'd3, 64'd4, 64'd7, 4'b0000, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
